// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-master Avalon-MM RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_watchdog.sv
// Counts consecutive stalled grant cycles; expired flags that the limit was reached.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

  // Saturates at TIMEOUT so the abort cycle sees a stable expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM RAM slave between the instruction
// and data masters, with a stall watchdog and sticky error flags.
module avalon_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     i_address,
  input  logic                  i_read,
  output logic                  i_waitrequest,
  output logic [DATA_W-1:0]     i_readdata,
  input  logic [ADDR_W-1:0]     d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W-1:0]     d_writedata,
  input  logic [DATA_W/8-1:0]   d_byteenable,
  output logic                  d_waitrequest,
  output logic [DATA_W-1:0]     d_readdata,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata,
  output logic                  timeout_err,
  output logic                  protocol_err
);

  state_e            state_q, state_d;
  owner_e            last_q, last_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              timeout_err_q, timeout_err_d;
  logic              protocol_err_q, protocol_err_d;

  logic i_req_c, d_req_c, granted_c, req_x_c;
  logic expired, wd_fire_c, done_c, abort_c, leave_c;

  // Request qualification and transaction-end conditions for the current owner.
  always_comb begin
    i_req_c   = i_read;
    d_req_c   = d_read | d_write;
    granted_c = (state_q == GRANT_I) | (state_q == GRANT_D);
    req_x_c   = ((state_q == GRANT_I) & i_req_c) | ((state_q == GRANT_D) & d_req_c);
    wd_fire_c = expired & waitrequest;
    done_c    = granted_c & req_x_c & ~waitrequest;
    abort_c   = granted_c & req_x_c & wd_fire_c;
    leave_c   = granted_c & (~req_x_c | done_c | abort_c);
  end

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .count_en (granted_c & waitrequest),
    .clear    ((state_q == IDLE) | leave_c),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_q         <= DATA;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      timeout_err_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      timeout_err_q  <= timeout_err_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Arbitration, completion bookkeeping and read-data capture.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    timeout_err_d  = timeout_err_q | abort_c;
    protocol_err_d = protocol_err_q | (d_read & d_write);
    case (state_q)
      IDLE: begin
        if (i_req_c && d_req_c) begin
          state_d = (last_q == DATA) ? GRANT_I : GRANT_D;
        end else if (i_req_c) begin
          state_d = GRANT_I;
        end else if (d_req_c) begin
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        if (leave_c) begin
          state_d = IDLE;
        end
        if (abort_c) begin
          last_d    = INST;
          i_rdata_d = '0;
        end else if (done_c) begin
          last_d    = INST;
          i_rdata_d = readdata;
        end
      end
      GRANT_D: begin
        if (leave_c) begin
          state_d = IDLE;
        end
        if (abort_c) begin
          last_d    = DATA;
          d_rdata_d = '0;
        end else if (done_c) begin
          last_d = DATA;
          if (d_read && !d_write) begin
            d_rdata_d = readdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave and master-side muxing; a watchdog abort forces a zero-data completion.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = i_rdata_q;
    d_readdata    = d_rdata_q;
    case (state_q)
      GRANT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = '1;
        i_waitrequest = waitrequest & ~expired;
        i_readdata    = wd_fire_c ? '0 : readdata;
      end
      GRANT_D: begin
        address       = d_address;
        read          = d_read & ~d_write;
        write         = d_write;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest & ~expired;
        d_readdata    = wd_fire_c ? '0 : readdata;
      end
      default: ;
    endcase
  end

  assign timeout_err  = timeout_err_q;
  assign protocol_err = protocol_err_q;

endmodule
